// File: rtl/gray_adaptive_binarize_if.sv
// Pixel stream in/out of the adaptive binarizer plus threshold control
// and frame-statistics status.
interface gray_adaptive_binarize_if;
    logic        per_frame_vsync;
    logic        per_frame_href;
    logic        per_frame_clken;
    logic [7:0]  per_img_Y;
    logic [10:0] per_setx;
    logic [9:0]  per_sety;
    logic        thresh_mode;
    logic [7:0]  manual_thresh;

    logic        post_frame_vsync;
    logic        post_frame_href;
    logic        post_frame_clken;
    logic [10:0] post_setx;
    logic [9:0]  post_sety;
    logic        post_img_Bit;
    logic [7:0]  cur_thresh;
    logic [7:0]  frame_mean;
    logic        frame_mean_valid;

    modport master (
        output per_frame_vsync,
        output per_frame_href,
        output per_frame_clken,
        output per_img_Y,
        output per_setx,
        output per_sety,
        output thresh_mode,
        output manual_thresh,
        input  post_frame_vsync,
        input  post_frame_href,
        input  post_frame_clken,
        input  post_setx,
        input  post_sety,
        input  post_img_Bit,
        input  cur_thresh,
        input  frame_mean,
        input  frame_mean_valid
    );

    modport slave (
        input  per_frame_vsync,
        input  per_frame_href,
        input  per_frame_clken,
        input  per_img_Y,
        input  per_setx,
        input  per_sety,
        input  thresh_mode,
        input  manual_thresh,
        output post_frame_vsync,
        output post_frame_href,
        output post_frame_clken,
        output post_setx,
        output post_sety,
        output post_img_Bit,
        output cur_thresh,
        output frame_mean,
        output frame_mean_valid
    );
endinterface

// File: rtl/gray_adaptive_binarize.sv
// Gray-to-binary with a threshold taken from the previous frame's mean
// luminance (divided during vertical blanking) or a manual host value.
module gray_adaptive_binarize #(
    parameter logic [11:0] IMG_HDISP  = 12'd1280,
    parameter logic [11:0] IMG_VDISP  = 12'd720,
    parameter logic [7:0]  DEF_THRESH = 8'd128
) (
    input logic clk,
    input logic rst,
    gray_adaptive_binarize_if.slave bus
);

    localparam int NPIX  = int'(IMG_HDISP) * int'(IMG_VDISP);
    localparam int CNT_W = $clog2(NPIX + 1);
    localparam int SUM_W = $clog2(NPIX * 255 + 1);
    localparam int IT_W  = $clog2(SUM_W);

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        DONE
    } state_t;

    state_t state;

    logic             vsync_d;
    logic             pix;
    logic             fall;
    logic             rise;

    logic [SUM_W-1:0] sum;
    logic [CNT_W-1:0] cnt;

    logic [SUM_W-1:0] dvd;
    logic [SUM_W-1:0] quo;
    logic [CNT_W-1:0] dsr;
    logic [CNT_W-1:0] rem;
    logic [IT_W-1:0]  iter;

    logic [CNT_W:0]   rem_sh;
    logic [CNT_W-1:0] rem_sub;
    logic             take;
    logic [7:0]       q_sat;

    logic [7:0]       pending;
    logic [7:0]       thresh_q;
    logic [7:0]       sel_thresh;
    logic [7:0]       live_thresh;
    logic [7:0]       mean_q;
    logic             valid_q;

    logic             vs_q;
    logic             hr_q;
    logic             ck_q;
    logic [10:0]      x_q;
    logic [9:0]       y_q;
    logic             bit_q;

    assign pix  = bus.per_frame_vsync
                & bus.per_frame_href
                & bus.per_frame_clken;
    assign fall = vsync_d & ~bus.per_frame_vsync;
    assign rise = ~vsync_d & bus.per_frame_vsync;

    always_comb begin
        rem_sh  = {rem, dvd[SUM_W-1]};
        take    = (rem_sh >= {1'b0, dsr});
        // true difference is below dsr, so the top bit is always zero
        rem_sub = rem_sh[CNT_W-1:0] - dsr;
        q_sat   = (|quo[SUM_W-1:8]) ? 8'hFF : quo[7:0];
    end

    always_comb begin
        sel_thresh  = bus.thresh_mode ? bus.manual_thresh : pending;
        // the first pixel of a frame already sees the new threshold
        live_thresh = rise ? sel_thresh : thresh_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_d  <= 1'b0;
            vs_q     <= 1'b0;
            hr_q     <= 1'b0;
            ck_q     <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            bit_q    <= 1'b0;
            thresh_q <= DEF_THRESH;
            pending  <= DEF_THRESH;
            mean_q   <= '0;
            valid_q  <= 1'b0;
            sum      <= '0;
            cnt      <= '0;
            dvd      <= '0;
            quo      <= '0;
            dsr      <= '0;
            rem      <= '0;
            iter     <= '0;
            state    <= IDLE;
        end else begin
            vsync_d <= bus.per_frame_vsync;
            vs_q    <= bus.per_frame_vsync;
            hr_q    <= bus.per_frame_href;
            ck_q    <= bus.per_frame_clken;
            x_q     <= bus.per_setx;
            y_q     <= bus.per_sety;
            bit_q   <= pix & (bus.per_img_Y > live_thresh);
            valid_q <= 1'b0;

            if (rise) begin
                thresh_q <= sel_thresh;
            end

            if (fall) begin
                sum <= '0;
                cnt <= '0;
            end else if (pix) begin
                sum <= sum + SUM_W'(bus.per_img_Y);
                cnt <= cnt + 1'b1;
            end

            unique case (state)
                IDLE: begin
                    if (fall && cnt != '0) begin
                        dvd   <= sum;
                        dsr   <= cnt;
                        rem   <= '0;
                        quo   <= '0;
                        iter  <= '0;
                        state <= DIV;
                    end
                end
                DIV: begin
                    dvd  <= {dvd[SUM_W-2:0], 1'b0};
                    rem  <= take ? rem_sub : rem_sh[CNT_W-1:0];
                    quo  <= {quo[SUM_W-2:0], take};
                    iter <= iter + 1'b1;
                    if (iter == IT_W'(SUM_W - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    mean_q  <= q_sat;
                    pending <= q_sat;
                    valid_q <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.post_frame_vsync = vs_q;
    assign bus.post_frame_href  = hr_q;
    assign bus.post_frame_clken = ck_q;
    assign bus.post_setx        = x_q;
    assign bus.post_sety        = y_q;
    assign bus.post_img_Bit     = bit_q;
    assign bus.cur_thresh       = thresh_q;
    assign bus.frame_mean       = mean_q;
    assign bus.frame_mean_valid = valid_q;

endmodule
